// File: rtl/dcache_dm.sv
// Direct-mapped write-through, no-write-allocate data cache: zero-cycle read hits, burst refill, stall via cpu_ready.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_dm #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              flush,
    output logic              flush_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int CNT_W = (OFFSET_W > 0) ? OFFSET_W : 1;
    localparam logic [CNT_W-1:0]   LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [INDEX_W-1:0] LAST_LINE = INDEX_W'(LINES - 1);
    localparam logic [ADDR_W-1:0]  OFF_MASK  = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, FLUSH} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LINES-1:0]    line_vld;
    logic [TAG_W-1:0]    tag_ram  [LINES];
    logic [DATA_W-1:0]   data_ram [LINES][WORDS];
    logic [CNT_W-1:0]    refill_cnt;
    logic [INDEX_W-1:0]  flush_cnt;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [CNT_W-1:0]    req_offset;
    logic                hit;
    logic                refill_done;

    assign req_tag     = cpu_addr[ADDR_W-1 -: TAG_W];
    assign req_index   = cpu_addr[OFFSET_W +: INDEX_W];
    assign req_offset  = CNT_W'(cpu_addr & OFF_MASK);
    assign hit         = line_vld[req_index] && (tag_ram[req_index] == req_tag);
    assign refill_done = (state == REFILL) && mem_ack && (refill_cnt == LAST_WORD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = FLUSH;
                end else if (cpu_req && cpu_we) begin
                    state_nxt = WRITE;
                end else if (cpu_req && !hit) begin
                    state_nxt = REFILL;
                end
            end
            REFILL:  if (refill_done) state_nxt = IDLE;
            WRITE:   if (mem_ack) state_nxt = IDLE;
            FLUSH:   if (flush_cnt == LAST_LINE) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        flush_busy = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (cpu_req && !cpu_we && !flush && hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = data_ram[req_index][req_offset];
                end
            end
            REFILL: begin
                // Burst always walks the line from word 0, independent of the requested offset.
                mem_req  = 1'b1;
                mem_addr = (cpu_addr & ~OFF_MASK) | ADDR_W'(refill_cnt);
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                cpu_ready = mem_ack;
            end
            FLUSH:   flush_busy = 1'b1;
            default: ;
        endcase
    end

    // Valid bits carry the only reset; a line becomes valid only on its final refill beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_vld   <= '0;
            refill_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (state == REFILL && mem_ack) begin
                refill_cnt <= (refill_cnt == LAST_WORD) ? '0 : refill_cnt + 1'b1;
            end
            if (refill_done) begin
                line_vld[req_index] <= 1'b1;
            end
            if (state == FLUSH) begin
                line_vld[flush_cnt] <= 1'b0;
                flush_cnt           <= flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == REFILL && mem_ack) begin
            data_ram[req_index][refill_cnt] <= mem_rdata;
        end
        if (refill_done) begin
            tag_ram[req_index] <= req_tag;
        end
        if (state == WRITE && mem_ack && hit) begin
            data_ram[req_index][req_offset] <= cpu_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    // The IDLE cycle right after a refill completes the missed read; it is not a hit.
    logic post_refill;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            post_refill <= 1'b0;
        end else begin
            post_refill <= refill_done;
            if (state == IDLE && cpu_ready && !post_refill && hit_cnt != 16'hFFFF) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (state == IDLE && state_nxt == REFILL && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: a line-level cache model predicts hit/miss, read data and memory traffic;
// a memory responder and a CPU-side monitor compare DUT activity against the predicted queues.
module tb_dcache_dm;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] data;
    } memop_t;

    typedef struct {
        bit          we;
        logic [15:0] data;
        bit          hit;
    } resp_t;

    logic        clock;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic        flush_busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    dcache_dm #(.ADDR_W(16), .DATA_W(16), .INDEX_W(4), .OFFSET_W(1)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .flush(flush), .flush_busy(flush_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    logic [15:0] mem     [65536];
    logic [15:0] ref_mem [65536];
    bit          mvalid  [16];
    int          mtag    [16];
    memop_t      exp_mem [$];
    resp_t       sb      [$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int lat = 2;
    int busy_cnt = 0;
    int m_hits = 0;
    int m_miss = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not occur as expected (cycle %0d)", name, cyc);
    endtask

    // Memory: acknowledges each request after 'lat' idle cycles and checks it against the predicted op.
    initial begin
        int     wait_cnt;
        memop_t m;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock);
            #2;
            mem_ack = 1'b0;
            if (reset || !mem_req) begin
                wait_cnt = 0;
            end else if (wait_cnt < lat) begin
                wait_cnt++;
            end else begin
                wait_cnt  = 0;
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                if (exp_mem.size() == 0) begin
                    fail_now("mem_unexpected_request");
                end else begin
                    m = exp_mem.pop_front();
                    check("mem_we", mem_we, m.we);
                    check("mem_addr", mem_addr, m.addr);
                    if (m.we) check("mem_wdata", mem_wdata, m.data);
                end
                if (mem_we) mem[mem_addr] = mem_wdata;
            end
        end
    end

    // CPU-side monitor: every completed access pops one predicted response.
    always @(negedge clock) begin
        resp_t r;
        if (!reset && flush_busy) busy_cnt++;
        if (!reset && cpu_ready) begin
            if (sb.size() == 0) begin
                fail_now("cpu_unexpected_ready");
            end else begin
                r = sb.pop_front();
                if (!r.we) begin
                    check("cpu_rdata", cpu_rdata, r.data);
                    check("zero_latency_hit", (cyc == start_cyc), r.hit);
                    check("read_done_mem_idle", mem_req, 1'b0);
                end else begin
                    check("write_ready_with_ack", mem_ack, 1'b1);
                end
            end
        end
    end

    // Model: line = (addr/2) mod 16, tag = addr/32; reads return the last value written to that address.
    task automatic access(input bit we, input logic [15:0] a, input logic [15:0] d, input bit with_flush);
        int     line;
        int     tg;
        int     n;
        bit     hit;
        resp_t  r;
        memop_t m;
        if (with_flush) begin
            for (int l = 0; l < 16; l++) mvalid[l] = 1'b0;
        end
        line = (int'(a) / 2) % 16;
        tg   = int'(a) / 32;
        hit  = mvalid[line] && (mtag[line] == tg);
        if (we) begin
            m.we = 1'b1; m.addr = a; m.data = d;
            exp_mem.push_back(m);
            ref_mem[a] = d;
            r.we = 1'b1; r.data = d; r.hit = 1'b0;
        end else begin
            if (!hit) begin
                for (int w = 0; w < 2; w++) begin
                    m.we = 1'b0; m.addr = 16'((int'(a) / 2) * 2 + w); m.data = '0;
                    exp_mem.push_back(m);
                end
                mvalid[line] = 1'b1;
                mtag[line]   = tg;
                m_miss++;
            end else begin
                m_hits++;
            end
            r.we = 1'b0; r.data = ref_mem[a]; r.hit = hit;
        end
        sb.push_back(r);
        flush     = with_flush;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        start_cyc = cyc;
        if (with_flush) begin
            @(posedge clock);
            #1;
            flush = 1'b0;
        end
        n = 0;
        forever begin
            @(negedge clock);
            if (cpu_ready) break;
            n++;
            if (n > 300) begin
                fail_now("cpu_ready_timeout");
                break;
            end
        end
        @(posedge clock);
        #1;
        cpu_req = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i * 40503 + 12345);
            ref_mem[i] = mem[i];
        end
        mem[16'h0012] = 16'hAAAA; ref_mem[16'h0012] = 16'hAAAA;
        mem[16'h0013] = 16'hBBBB; ref_mem[16'h0013] = 16'hBBBB;
        for (int l = 0; l < 16; l++) begin
            mvalid[l] = 1'b0;
            mtag[l]   = 0;
        end
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; flush = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_cpu_ready", cpu_ready, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 16'h0);
        check("rst_flush_busy", flush_busy, 1'b0);
        reset = 1'b0;

        lat = 2;
        access(1'b0, 16'h0012, 16'h0, 1'b0);   // miss: burst 0x12, 0x13
        access(1'b0, 16'h0013, 16'h0, 1'b0);   // hit on second word
        access(1'b1, 16'h0012, 16'h1234, 1'b0); // write hit
        access(1'b0, 16'h0012, 16'h0, 1'b0);
        access(1'b1, 16'h0100, 16'h5555, 1'b0); // write miss, no allocate
        access(1'b0, 16'h0100, 16'h0, 1'b0);
        access(1'b0, 16'h0010, 16'h0, 1'b0);   // index 8 conflict sequence
        access(1'b0, 16'h0030, 16'h0, 1'b0);
        access(1'b0, 16'h0010, 16'h0, 1'b0);

        busy_cnt = 0;
        access(1'b0, 16'h0013, 16'h0, 1'b1);   // flush wins over a would-be hit
        check("flush_busy_cycles", busy_cnt, 16);
        access(1'b0, 16'h0100, 16'h0, 1'b0);
        access(1'b0, 16'h0010, 16'h0, 1'b0);

        // Reset one cycle after the first refill beat; the line must not become valid.
        a = 16'h0046;
        begin
            memop_t m;
            m.we = 1'b0; m.addr = 16'h0046; m.data = '0;
            exp_mem.push_back(m);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        n = 0;
        while (!mem_ack && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!mem_ack) fail_now("reset_test_first_ack");
        @(posedge clock);
        #1;
        reset = 1'b1; cpu_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midrefill_rst_mem_req", mem_req, 1'b0);
        check("midrefill_rst_cpu_ready", cpu_ready, 1'b0);
        for (int l = 0; l < 16; l++) mvalid[l] = 1'b0;
        m_hits = 0;
        m_miss = 0;
        access(1'b0, a, 16'h0, 1'b0);
`ifdef DCACHE_STATS_EN
        check("stats_hit_after_reset", hit_cnt, 16'd0);
        check("stats_miss_after_reset", miss_cnt, 16'd1);
`endif

        for (int i = 0; i < 300; i++) begin
            lat = $urandom_range(0, 3);
            a   = 16'($urandom_range(0, 127));
            if ($urandom_range(0, 19) == 0) begin
                access(1'b0, a, 16'h0, 1'b1);
            end else if ($urandom_range(0, 9) < 3) begin
                access(1'b1, a, 16'($urandom), 1'b0);
            end else begin
                access(1'b0, a, 16'h0, 1'b0);
            end
        end

        repeat (4) @(posedge clock);
        #1;
        check("mem_ops_outstanding", exp_mem.size(), 0);
        check("responses_outstanding", sb.size(), 0);
`ifdef DCACHE_STATS_EN
        check("stats_hit_final", hit_cnt, 16'(m_hits));
        check("stats_miss_final", miss_cnt, 16'(m_miss));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache.
- Sits between the 5-stage CPU's MEM stage (d_addr/d_we/d_dataout side) and the word-addressed data memory.
- Generalises the fixed single-word-line cache: configurable line count, words per line and width.
- Multi-word burst refill, explicit memory handshake, and a flush sequence.

Parameters:
ADDR_W, 16, word address width
DATA_W, 16, data word width
INDEX_W, 4, log2 of line count (2^INDEX_W lines)
OFFSET_W, 1, log2 of words per line (0 allowed = one word per line)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU access request, held until cpu_ready
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid when cpu_ready & ~cpu_we
cpu_ready  out  1  access complete this cycle; low = stall pipeline
flush  in  1  invalidate all lines (sampled in IDLE only)
flush_busy  out  1  high while invalidation in progress
mem_req  out  1  memory request, held with stable addr/data until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  single-cycle completion pulse

Behaviour:
- Address split: offset = addr[OFFSET_W-1:0]; index = addr[OFFSET_W+INDEX_W-1:OFFSET_W]; tag = remaining upper bits.
- Storage: per line one valid bit, one tag, 2^OFFSET_W data words. Data/tag arrays need no reset.
- States: IDLE, REFILL, WRITE, FLUSH.
- Reset (any state, including mid-refill, mid-write or mid-flush):
  - State -> IDLE; all valid bits cleared; refill/flush counters 0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_ready=0, cpu_rdata=0, flush_busy=0.
  - A partially refilled line is never validated.
- IDLE, read hit (valid & tag match): cpu_ready=1 combinationally in the same cycle; cpu_rdata = stored word. Zero-cycle latency, no memory traffic.
- IDLE, read miss: next state REFILL with word counter = 0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, counter}. The burst starts at offset 0 regardless of the requested offset.
  - Each mem_ack writes mem_rdata into word[counter]; counter increments and mem_addr updates the next cycle. mem_req may stay high between beats.
  - After the ack of the last word (counter = 2^OFFSET_W-1): set valid and tag, return to IDLE.
  - cpu_ready stays 0 throughout. The held request hits on the following IDLE cycle.
  - Miss penalty = sum of ack latencies + 1 cycle.
- IDLE, write: next state WRITE.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - On mem_ack: cpu_ready=1 in the same cycle and return to IDLE.
  - If the line hits in that cycle, the cached word is updated. A write miss leaves the cache unchanged (no allocate).
- flush in IDLE:
  - Takes priority over a simultaneous cpu_req. cpu_ready=0 that cycle.
  - Enter FLUSH: clear one line's valid bit per cycle, index 0 to 2^INDEX_W-1, flush_busy=1, then return to IDLE.
  - A flush asserted in other states is ignored; the requester holds it.
- cpu_req low in IDLE: no activity, cpu_ready=0.
- mem_ack outside REFILL/WRITE: ignored.
- cpu_addr, cpu_we and cpu_wdata must be stable while cpu_req=1 and cpu_ready=0 (protocol requirement on the CPU).

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt and miss_cnt, both 16 bits, reset 0, saturating at 0xFFFF.
  - hit_cnt increments once per read hit with cpu_ready=1, excluding the post-refill completion.
  - miss_cnt increments once per read transition IDLE->REFILL.
  - Writes are not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Defaults, after reset: read 0x0012, memory acks 2 cycles after each request with data 0xAAAA then 0xBBBB.
   - Bursts go to 0x0012 then 0x0013.
   - cpu_ready rises after the burst with cpu_rdata=0xAAAA.
   - An immediate read of 0x0013 returns 0xBBBB in the same cycle with mem_req=0.
2. Write hit: after test 1, write 0x1234 to 0x0012.
   - mem_req/mem_we set with addr 0x0012 and data 0x1234; cpu_ready coincides with mem_ack.
   - A subsequent read of 0x0012 hits with 0x1234 and no memory traffic.
3. Write miss: write 0x5555 to 0x0100 (line invalid).
   - One memory write.
   - A subsequent read of 0x0100 misses (REFILL burst at 0x0100/0x0101).
4. Conflict: read 0x0010, then 0x0030 (same index 8, tags 0 and 1), then 0x0010 again.
   - Three refills; the third returns the original data.
5. Flush: with 3 valid lines, assert flush for 1 cycle.
   - flush_busy high exactly 16 cycles.
   - All subsequent reads miss.
   - A cpu_req asserted with flush stalls until after FLUSH.
6. Reset mid-refill: assert reset 1 cycle after the first mem_ack of a 2-word refill.
   - Next cycle mem_req=0 and cpu_ready=0.
   - A re-read of the same address misses and performs a full 2-word refill.
   - With DCACHE_STATS_EN: hit_cnt=0 and miss_cnt=1 after this re-read.
